leds_board: RTL and testbench
=============================

LEDS_BOARD -- requirements
Module: leds_board

Interface
REQ-001 Parameter CLK_DIV, default 50: CLK cycles per SR_CLK half-period (1 MHz shift clock at 100 MHz CLK); legal range 1..255.
REQ-002 Parameter REFRESH_DIV, default 100000: CLK cycles between periodic refresh frames (1 ms at 100 MHz); legal range >= 64*CLK_DIV.
REQ-003 Port CLK  input  1  system clock, active posedge.
REQ-004 Port RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port LEDS  input  16  requested LED states, bit n drives shift-register output n.
REQ-006 Port BUSY  output  1  high while a frame is being shifted or latched.
REQ-007 Port SR_DATA  output  1  serial data to the 74HC595 chain.
REQ-008 Port SR_CLK  output  1  shift clock; the chain samples on its rising edge.
REQ-009 Port SR_LATCH  output  1  storage-register latch; the chain transfers on its rising edge.
REQ-010 Port SR_OE_N  output  1  output enable, active low.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
REQ-012 IDLE->LOAD SHALL occur when the pending flag is set; pending SHALL be set by a refresh tick or by LEDS != last-sent value.
REQ-013 LOAD SHALL last 1 cycle: it captures LEDS into the shadow register, clears pending, sets the bit counter to 15 and drives SR_DATA = LEDS[15].
REQ-014 Bits SHALL be sent MSB first, bit 15 to bit 0.
REQ-015 Each bit SHALL take SHIFT_LO (SR_CLK=0, SR_DATA stable, CLK_DIV cycles) followed by SHIFT_HI (SR_CLK=1, CLK_DIV cycles).
REQ-016 SR_DATA SHALL change only on entry to SHIFT_LO, never while SR_CLK=1.
REQ-017 After bit 0, LATCH SHALL hold SR_LATCH=1 for CLK_DIV cycles, then the FSM SHALL return to IDLE and the shadow SHALL become the last-sent value.
REQ-018 Frame length from LOAD through the last LATCH cycle SHALL be exactly 1 + 33*CLK_DIV cycles.
REQ-019 BUSY SHALL be 1 in every state except IDLE.
REQ-020 The refresh counter SHALL free-run modulo REFRESH_DIV and SHALL not be restarted by frames.
REQ-021 A LEDS change or refresh tick during BUSY SHALL only set pending; the frame in progress SHALL keep its shadow value, and IDLE SHALL exit to LOAD on the next cycle.
REQ-022 Multiple triggers during one frame SHALL produce exactly one following frame.
REQ-023 A change and a tick in the same cycle SHALL count as one trigger.
REQ-024 SR_OE_N SHALL go low on the cycle after the first completed LATCH following reset and then stay low until reset.

Reset
REQ-025 While RESET=1, the block SHALL force state IDLE, BUSY=0, SR_DATA=0, SR_CLK=0, SR_LATCH=0 and SR_OE_N=1, and clear the counters and shadow.
REQ-026 Last-sent SHALL reset to 16'h0000 and pending SHALL reset to 1, so that the first frame starts on the first cycle after reset release.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no partial latch pulse SHALL be emitted.

Structure
REQ-028 The FSM state enum and the default CLK_DIV/REFRESH_DIV constants SHALL live in the shared package theremin_board_pkg.
REQ-029 The CLK_DIV enable generator SHALL be one sub-module, clk_en_div, reusable by encoders_board.

Verification (CLK_DIV=2, REFRESH_DIV=1000 unless stated)
REQ-030 Reset release with LEDS=16'hA5C3 -> 16 SR_CLK rising edges sample 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; one SR_LATCH pulse of 2 cycles; frame = 67 cycles; SR_OE_N falls the cycle after.
REQ-031 LEDS changed 16'h0001->16'h8000 at cycle 20 of a frame -> current frame latches 16'h0001; next LOAD one cycle after IDLE re-entry latches 16'h8000.
REQ-032 LEDS static at 16'h1234 -> frames start every 1000 cycles with identical bit pattern; BUSY high 67 of 1000 cycles.
REQ-033 Three LEDS changes plus a refresh tick within one frame -> exactly one extra frame, carrying the final value.
REQ-034 RESET asserted at cycle 40 of a frame -> all outputs at reset values asynchronously; no SR_LATCH rise; SR_OE_N=1 until the next full frame completes.
REQ-035 CLK_DIV=1 -> frame = 34 cycles; SR_CLK toggles every cycle; SR_DATA never changes while SR_CLK=1.

Source files
------------

// File: rtl/theremin_board_pkg.sv
// Shared types and default timing constants
// for the theremin board peripheral blocks.
package theremin_board_pkg;

    localparam int DEF_CLK_DIV     = 50;
    localparam int DEF_REFRESH_DIV = 100000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } led_state_t;

endpackage

// File: rtl/clk_en_div.sv
// One-cycle enable every DIV clocks; clr holds
// the count at zero so a phase starts aligned.
module clk_en_div #(
    parameter int DIV = 50
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    output logic en
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

    assign en = !clr && (cnt == LAST);

endmodule

// File: rtl/leds_board.sv
// Serialises 16 LED states into a 74HC595 chain,
// on LEDS change and on a periodic refresh.
module leds_board
    import theremin_board_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] LEDS,
    output logic        BUSY,
    output logic        SR_DATA,
    output logic        SR_CLK,
    output logic        SR_LATCH,
    output logic        SR_OE_N
);

    localparam int RW = $clog2(REFRESH_DIV);

    led_state_t state, next;

    logic [RW-1:0] rcnt;
    logic          tick;
    logic          pending;
    logic [15:0]   last_sent;
    logic [15:0]   shadow;
    logic [15:0]   cmp_val;
    logic [3:0]    bitc;
    logic          sd;
    logic          oe_n;
    logic          div_clr;
    logic          en;
    logic          change;

    assign div_clr = (state == IDLE) || (state == LOAD);

    clk_en_div #(
        .DIV(CLK_DIV)
    ) u_div (
        .CLK  (CLK),
        .RESET(RESET),
        .clr  (div_clr),
        .en   (en)
    );

    assign tick = (rcnt == RW'(REFRESH_DIV - 1));

    // While busy, compare against the frame on the wire
    // so the frame itself does not re-trigger.
    assign cmp_val = (state == IDLE) ? last_sent : shadow;
    assign change  = (state != LOAD) && (LEDS != cmp_val);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:     if (pending) next = LOAD;
            LOAD:     next = SHIFT_LO;
            SHIFT_LO: if (en) next = SHIFT_HI;
            SHIFT_HI: if (en) next = (bitc == 4'd0) ? LATCH : SHIFT_LO;
            LATCH:    if (en) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state != IDLE);
        SR_CLK   = (state == SHIFT_HI);
        SR_LATCH = (state == LATCH);
        SR_DATA  = sd;
        SR_OE_N  = oe_n;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rcnt      <= '0;
            pending   <= 1'b1;
            last_sent <= '0;
            shadow    <= '0;
            bitc      <= '0;
            sd        <= 1'b0;
            oe_n      <= 1'b1;
        end else begin
            rcnt    <= tick ? '0 : rcnt + RW'(1);
            pending <= tick | change | (pending & (state != LOAD));
            if (state == LOAD) begin
                shadow <= LEDS;
                bitc   <= 4'd15;
                sd     <= LEDS[15];
            end
            if (state == SHIFT_HI && en && bitc != 4'd0) begin
                bitc <= bitc - 4'd1;
                sd   <= shadow[bitc - 4'd1];
            end
            if (state == LATCH && en) begin
                last_sent <= shadow;
                oe_n      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_leds_board.sv
// Scoreboard bench: frame-position reference model
// predicts every pin; a monitor checks latched words.
module tb_leds_board;

    localparam int D = 2;
    localparam int R = 1000;
    localparam int F = 1 + 33 * D;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] LEDS = 16'hA5C3;
    logic        BUSY, SR_DATA, SR_CLK, SR_LATCH, SR_OE_N;
    logic        b2, d2, c2, l2, o2;

    int n_checks = 0;
    int n_fail = 0;

    leds_board #(.CLK_DIV(D), .REFRESH_DIV(R)) dut (
        .CLK(CLK), .RESET(RESET), .LEDS(LEDS),
        .BUSY(BUSY), .SR_DATA(SR_DATA), .SR_CLK(SR_CLK),
        .SR_LATCH(SR_LATCH), .SR_OE_N(SR_OE_N)
    );

    leds_board #(.CLK_DIV(1), .REFRESH_DIV(100)) dut1 (
        .CLK(CLK), .RESET(RESET), .LEDS(LEDS),
        .BUSY(b2), .SR_DATA(d2), .SR_CLK(c2),
        .SR_LATCH(l2), .SR_OE_N(o2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: pos = cycle within frame (0 = load), -1 idle.
    int          pos = -1;
    bit          pend = 1'b1;
    logic [15:0] last = '0;
    logic [15:0] shad = '0;
    int          rcnt = 0;
    bit          oe = 1'b1;
    logic [15:0] sb[$];

    always @(posedge CLK or posedge RESET) begin
        bit tk;
        if (RESET) begin
            pos = -1; pend = 1; last = '0; shad = '0;
            rcnt = 0; oe = 1; sb.delete();
        end else begin
            tk = (rcnt == R - 1);
            rcnt = (rcnt + 1) % R;
            if (pos < 0) begin
                if (pend) pos = 0;
                pend = pend || tk || (LEDS != last);
            end else if (pos == 0) begin
                shad = LEDS;
                sb.push_back(LEDS);
                pend = tk;
                pos = 1;
            end else begin
                pend = pend || tk || (LEDS != shad);
                if (pos == F - 1) begin
                    last = shad; oe = 0; pos = -1;
                end else pos++;
            end
        end
    end

    int          nbits = 0, busy_run = 0, lat_run = 0;
    logic [15:0] word = '0;
    bit          p_clk = 0, p_lat = 0, p_busy = 0, p_dat = 0;

    always @(negedge CLK) begin
        bit ec, el;
        int idx;
        if (RESET) begin
            check("rst_data", 32'(SR_DATA), 32'(0));
            nbits = 0; busy_run = 0; lat_run = 0;
            p_clk = 0; p_lat = 0; p_busy = 0;
        end else begin
            ec = (pos >= 1) && (pos <= 32 * D) && (((pos - 1) / D) % 2 == 1);
            el = (pos > 32 * D);
            check("busy", 32'(BUSY), 32'(pos >= 0));
            check("sr_clk", 32'(SR_CLK), 32'(ec));
            check("sr_latch", 32'(SR_LATCH), 32'(el));
            check("sr_oe_n", 32'(SR_OE_N), 32'(oe));
            if (pos >= 1 && pos <= 32 * D) begin
                idx = 15 - (pos - 1) / (2 * D);
                check("sr_data", 32'(SR_DATA), 32'(shad[idx]));
            end
            if (p_clk && SR_CLK)
                check("data_stable", 32'(SR_DATA), 32'(p_dat));
            if (SR_CLK && !p_clk) begin
                word = {word[14:0], SR_DATA};
                nbits++;
            end
            if (SR_LATCH && !p_lat) begin
                check("nbits", 32'(nbits), 32'(16));
                nbits = 0;
                if (sb.size() == 0)
                    check("extra_frame", 32'(word), 32'hFFFF_FFFF);
                else
                    check("latched_word", 32'(word), 32'(sb.pop_front()));
            end
            if (SR_LATCH) lat_run++;
            else if (p_lat) begin
                check("latch_len", 32'(lat_run), 32'(D));
                lat_run = 0;
            end
            if (BUSY) busy_run++;
            else if (p_busy) begin
                check("frame_len", 32'(busy_run), 32'(F));
                busy_run = 0;
            end
            p_clk = SR_CLK; p_lat = SR_LATCH;
            p_busy = BUSY; p_dat = SR_DATA;
        end
    end

    int  n2 = 0, run2 = 0, lrun2 = 0;
    bit  pc2 = 0, pb2 = 0, pd2 = 0, pl2 = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            n2 = 0; run2 = 0; lrun2 = 0;
            pc2 = 0; pb2 = 0; pl2 = 0;
        end else begin
            if (pc2 && c2) check("d1_stable", 32'(d2), 32'(pd2));
            if (c2 && !pc2) n2++;
            if (l2 && !pl2) begin
                check("d1_nbits", 32'(n2), 32'(16));
                n2 = 0;
            end
            if (l2) lrun2++;
            else if (pl2) begin
                check("d1_latch_len", 32'(lrun2), 32'(1));
                lrun2 = 0;
            end
            if (b2) run2++;
            else if (pb2) begin
                check("d1_frame_len", 32'(run2), 32'(34));
                run2 = 0;
            end
            pc2 = c2; pb2 = b2; pd2 = d2; pl2 = l2;
        end
    end

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("wait_pos", 32'(pos), 32'(p));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(pos < 0 && !pend) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("wait_idle", 32'(pos < 0 && !pend), 32'(1));
    endtask

    task automatic reset_checks();
        check("rst_busy", 32'(BUSY), 32'(0));
        check("rst_clk", 32'(SR_CLK), 32'(0));
        check("rst_latch", 32'(SR_LATCH), 32'(0));
        check("rst_oe_n", 32'(SR_OE_N), 32'(1));
        check("rst_sdata", 32'(SR_DATA), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        reset_checks();
        #2 RESET = 1'b0;
        wait_idle();
        LEDS = 16'h1234;
        wait_idle();
        repeat (2100) @(negedge CLK);

        LEDS = 16'h0001;
        wait_pos(20);
        LEDS = 16'h8000;
        wait_idle();

        LEDS = 16'h1111;
        wait_pos(5);
        LEDS = 16'h2222;
        wait_pos(15);
        LEDS = 16'h3333;
        wait_pos(25);
        LEDS = 16'h4444;
        wait_idle();

        LEDS = 16'h5A5A;
        wait_pos(40);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 reset_checks();
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b0;
        wait_idle();

        repeat (3000) begin
            @(negedge CLK);
            if ($urandom_range(39) == 0)
                LEDS = 16'($urandom);
        end
        wait_idle();
        repeat (100) @(negedge CLK);
        wait_idle();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
